// File: rtl/aemb_bsft_pkg.sv
// aemb_bsft_pkg: shared kind codes, tag type and latency for the shifter arbiter
package aemb_bsft_pkg;
  localparam logic [1:0] BSF_SRL = 2'd0;
  localparam logic [1:0] BSF_SRA = 2'd1;
  localparam logic [1:0] BSF_SLL = 2'd2;
  localparam logic [1:0] BSF_RSV = 2'd3;
  localparam int BSF_LAT = 2;
  localparam int BSF_IDW = 3;
  typedef struct packed {
    logic vld;
    logic [BSF_IDW-1:0] id;
    logic err;
  } bsf_tag_t;
endpackage

// File: rtl/aemb_bsft_arb_if.sv
// aemb_bsft_arb_if: requester, shifter and response signals of the shifter arbiter
interface aemb_bsft_arb_if #(parameter int NREQ = 2, parameter int IDW = 1);
  logic [NREQ-1:0] req_vld;
  logic [NREQ-1:0] req_rdy;
  logic [32*NREQ-1:0] req_opa;
  logic [32*NREQ-1:0] req_opb;
  logic [2*NREQ-1:0] req_knd;
  logic flush;
  logic [31:0] x_opa;
  logic [31:0] x_opb;
  logic [1:0] x_imm;
  logic dena;
  logic [31:0] m_bsf;
  logic rsp_vld;
  logic rsp_rdy;
  logic [IDW-1:0] rsp_id;
  logic [31:0] rsp_dat;
  logic rsp_err;
  modport slave (
    input req_vld, req_opa, req_opb, req_knd, flush, m_bsf, rsp_rdy,
    output req_rdy, x_opa, x_opb, x_imm, dena, rsp_vld, rsp_id, rsp_dat, rsp_err
  );
  modport master (
    output req_vld, req_opa, req_opb, req_knd, flush, m_bsf, rsp_rdy,
    input req_rdy, x_opa, x_opb, x_imm, dena, rsp_vld, rsp_id, rsp_dat, rsp_err
  );
endinterface

// File: rtl/aemb_rr_arb.sv
// aemb_rr_arb: round-robin pick of the nearest requester after last_i
module aemb_rr_arb #(parameter int N = 2, parameter int W = 1) (
  input  logic en_i,
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] id_o,
  output logic vld_o
);
  int d, bd;
  // smallest circular distance from last_i wins
  always_comb begin
    id_o = '0;
    vld_o = 1'b0;
    d = 0;
    bd = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + 2 * N - 1 - int'(last_i)) % N;
      if (en_i && req_i[i] && (!vld_o || d < bd)) begin
        vld_o = 1'b1;
        bd = d;
        id_o = W'(i);
      end
    end
    gnt_o = vld_o ? (N'(1) << id_o) : '0;
  end
endmodule

// File: rtl/aemb_bsft_arb.sv
// aemb_bsft_arb: shares one 2-cycle barrel shifter among NREQ requesters
module aemb_bsft_arb
  import aemb_bsft_pkg::*;
#(parameter int NREQ = 2, parameter int IDW = 1) (
  input logic gclk,
  input logic grst,
  aemb_bsft_arb_if.slave bus
);
  bsf_tag_t s1_q, s1_d, s2_q, s2_d, issue;
  logic [IDW-1:0] last_q, last_d, gnt_id;
  logic [NREQ-1:0] gnt;
  logic gnt_vld, dena, err_w;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0] imm_q, imm_d, knd_w;
  assign dena = !(s2_q.vld && !bus.rsp_rdy);
  aemb_rr_arb #(.N(NREQ), .W(IDW)) u_arb (
    .en_i(dena && !bus.flush && !grst),
    .req_i(bus.req_vld),
    .last_i(last_q),
    .gnt_o(gnt),
    .id_o(gnt_id),
    .vld_o(gnt_vld)
  );
  // operand mux from the winner; without a grant the last values hold so the shifter stays quiet
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    knd_w = imm_q;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        opa_d = bus.req_opa[32*i +: 32];
        opb_d = bus.req_opb[32*i +: 32];
        knd_w = bus.req_knd[2*i +: 2];
      end
    imm_d = knd_w;
  end
  // tag pipeline advances with the shifter enable; flush kills both stages
  always_comb begin
    issue = gnt_vld ? bsf_tag_t'{vld: 1'b1, id: BSF_IDW'(gnt_id), err: knd_w == BSF_RSV} : '0;
    s1_d = dena ? issue : s1_q;
    s2_d = dena ? s1_q : s2_q;
    s1_d.vld = s1_d.vld && !bus.flush;
    s2_d.vld = s2_d.vld && !bus.flush;
    last_d = gnt_vld ? gnt_id : last_q;
  end
  // state registers
  always_ff @(posedge gclk or posedge grst)
    if (grst) begin
      s1_q <= '0;
      s2_q <= '0;
      last_q <= IDW'(NREQ - 1);
      opa_q <= '0;
      opb_q <= '0;
      imm_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      last_q <= last_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      imm_q <= imm_d;
    end
  assign err_w = s2_q.vld && s2_q.err;
  assign bus.req_rdy = gnt;
  assign bus.x_opa = opa_d;
  assign bus.x_opb = opb_d;
  assign bus.x_imm = imm_d;
  assign bus.dena = dena;
  assign bus.rsp_vld = s2_q.vld;
  assign bus.rsp_id = IDW'(s2_q.id);
  assign bus.rsp_err = err_w;
  assign bus.rsp_dat = err_w ? 32'd0 : bus.m_bsf;
endmodule

// File: tb/tb_aemb_bsft_arb.sv
// tb_aemb_bsft_arb: random and directed checks of the shifter arbiter against a queue model
module tb_aemb_bsft_arb;
  import aemb_bsft_pkg::*;
  localparam int NREQ = 3;
  localparam int IDW = 2;
  typedef struct {
    int id;
    logic [31:0] dat;
    logic err;
    int age;
  } exp_t;
  logic gclk = 1'b0;
  logic grst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int m_last;
  exp_t q[$];
  logic [31:0] opa [NREQ];
  logic [31:0] opb [NREQ];
  logic [1:0] knd [NREQ];
  logic [31:0] sh_a, sh_b, held;
  logic [1:0] sh_k;
  aemb_bsft_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  aemb_bsft_arb #(.NREQ(NREQ), .IDW(IDW)) dut (.gclk(gclk), .grst(grst), .bus(bus));
  always #5 gclk = ~gclk;
  function automatic logic [31:0] shf(logic [31:0] a, logic [31:0] b, logic [1:0] k);
    case (k)
      BSF_SRL: return a >> b[4:0];
      BSF_SRA: return 32'($signed(a) >>> b[4:0]);
      BSF_SLL: return a << b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  // external 2-stage shifter frozen by dena
  always @(posedge gclk)
    if (bus.dena) begin
      sh_a <= bus.x_opa;
      sh_b <= bus.x_opb;
      sh_k <= bus.x_imm;
      bus.m_bsf <= shf(sh_a, sh_b, sh_k);
    end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] xp);
    n_cmp++;
    assert (obs === xp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, xp);
    end
  endtask
  task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic [1:0] k);
    opa[i] = a;
    opb[i] = b;
    knd[i] = k;
    bus.req_opa[32*i +: 32] = a;
    bus.req_opb[32*i +: 32] = b;
    bus.req_knd[2*i +: 2] = k;
  endtask
  task automatic step();
    logic e_vld, e_dena;
    logic [NREQ-1:0] e_rdy;
    int w;
    #1;
    e_vld = q.size() > 0 && q[0].age >= BSF_LAT;
    e_dena = !(e_vld && !bus.rsp_rdy);
    w = -1;
    if (e_dena && !bus.flush)
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && bus.req_vld[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
    e_rdy = (w >= 0) ? NREQ'(1) << w : '0;
    chk("dena", 32'(bus.dena), 32'(e_dena));
    chk("req_rdy", 32'(bus.req_rdy), 32'(e_rdy));
    chk("rsp_vld", 32'(bus.rsp_vld), 32'(e_vld));
    if (e_vld) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      chk("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
      chk("rsp_dat", bus.rsp_dat, q[0].dat);
    end
    if (w >= 0) begin
      chk("x_opa", bus.x_opa, opa[w]);
      chk("x_opb", bus.x_opb, opb[w]);
      chk("x_imm", 32'(bus.x_imm), 32'(knd[w]));
    end
    if (bus.flush) q.delete();
    else if (e_dena) begin
      if (e_vld) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (w >= 0) begin
        q.push_back('{w, (knd[w] == BSF_RSV) ? 32'd0 : shf(opa[w], opb[w], knd[w]), knd[w] == BSF_RSV, 1});
        m_last = w;
      end
    end
    @(posedge gclk);
    @(negedge gclk);
  endtask
  task automatic single(int i, logic [31:0] a, logic [31:0] b, logic [1:0] k, logic [31:0] xd);
    set_req(i, a, b, k);
    bus.req_vld = NREQ'(1) << i;
    step();
    bus.req_vld = '0;
    step();
    #1;
    chk("single_vld", 32'(bus.rsp_vld), 32'd1);
    chk("single_id", 32'(bus.rsp_id), 32'(i));
    chk("single_dat", bus.rsp_dat, xd);
    chk("single_err", 32'(bus.rsp_err), 32'(k == BSF_RSV));
    step();
  endtask
  task automatic chk_reset();
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    chk("rst_dena", 32'(bus.dena), 32'd1);
    chk("rst_x_opa", bus.x_opa, 32'd0);
    chk("rst_x_opb", bus.x_opb, 32'd0);
    chk("rst_x_imm", 32'(bus.x_imm), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
  endtask
  initial begin
    bus.req_vld = '1;
    bus.flush = 1'b0;
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'd0, 32'd0, BSF_SRL);
    #1;
    chk_reset();
    @(negedge gclk);
    grst = 1'b0;
    bus.req_vld = '0;
    m_last = NREQ - 1;
    step();
    single(0, 32'h1, 32'd4, BSF_SLL, 32'h10);
    single(1, 32'h8000_0000, 32'd31, BSF_SRA, 32'hFFFF_FFFF);
    single(1, 32'h8000_0000, 32'd31, BSF_SRL, 32'h1);
    set_req(0, 32'h8000_0000, 32'd31, BSF_SRA);
    set_req(1, 32'h8000_0000, 32'd31, BSF_SRL);
    bus.req_vld = 3'b011;
    repeat (4) step();
    bus.req_vld = '0;
    repeat (3) step();
    bus.req_vld = 3'b011;
    step();
    step();
    #1;
    held = bus.rsp_dat;
    bus.rsp_rdy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("bp_dena", 32'(bus.dena), 32'd0);
      chk("bp_hold", bus.rsp_dat, held);
      step();
    end
    bus.rsp_rdy = 1'b1;
    bus.req_vld = '0;
    repeat (4) step();
    single(2, $urandom, $urandom, BSF_RSV, 32'd0);
    single(2, 32'h1, 32'd1, BSF_SLL, 32'h2);
    bus.req_vld = 3'b011;
    step();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.req_vld = '0;
    step();
    step();
    bus.req_vld = 3'b111;
    step();
    bus.req_vld = '0;
    repeat (3) step();
    for (int n = 0; n < 400; n++) begin
      bus.req_vld = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 2'($urandom));
      bus.rsp_rdy = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      step();
    end
    bus.flush = 1'b0;
    bus.rsp_rdy = 1'b1;
    bus.req_vld = '1;
    step();
    step();
    #2;
    grst = 1'b1;
    #1;
    chk_reset();
    @(negedge gclk);
    grst = 1'b0;
    q.delete();
    m_last = NREQ - 1;
    set_req(0, 32'h1, 32'hFFFF_FFE3, BSF_SLL);
    bus.req_vld = '1;
    #1;
    chk("rst_first_gnt", 32'(bus.req_rdy), 32'd1);
    step();
    bus.req_vld = '0;
    step();
    #1;
    chk("rst_shamt_dat", bus.rsp_dat, 32'h8);
    chk("rst_shamt_id", 32'(bus.rsp_id), 32'd0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aemb_bsft_arb.md
# aemb_bsft_arb

Arbiter and sequencer for the 2-cycle barrel shifter. Shares one shifter instance among `NREQ` requesters, such as hardware threads or a co-issue slot. It grants one request per cycle round-robin and drives the shifter operands, kind code and enable. It tracks each in-flight operation with a 2-deep tag pipeline matched to the shifter latency, and returns results over a valid/ready response port. Back-pressure on the response port freezes the shifter through its enable.

## Interface
- `NREQ`, default 2: number of requesters, 2..8.
- `IDW`, default 1: requester-id width, equal to ceil(log2(NREQ)) and at least 1.
- `gclk`  in  1  clock; all logic is on the rising edge.
- `grst`  in  1  reset, asynchronous and active-high.
- `req_vld`  in  NREQ  request valid, one bit per requester.
- `req_rdy`  out  NREQ  request accepted this cycle; one-hot or zero.
- `req_opa`  in  32*NREQ  operand A (shiftee); slice i belongs to requester i.
- `req_opb`  in  32*NREQ  operand B; only bits [4:0] of each slice are used.
- `req_knd`  in  2*NREQ  shift kind: 0 = SRL, 1 = SRA, 2 = SLL, 3 = reserved.
- `flush`  in  1  kill all in-flight operations.
- `x_opa`, `x_opb`  out  32  shifter operands.
- `x_imm`  out  2  shifter kind, driven to the shifter's imm[10:9].
- `dena`  out  1  shifter enable.
- `m_bsf`  in  32  shifter result.
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  response accepted.
- `rsp_id`  out  IDW  id of the requester that owns the response.
- `rsp_dat`  out  32  response data; equals `m_bsf`, or 0 when `rsp_err` is set.
- `rsp_err`  out  1  the request carried reserved kind 3.

## Operation
- **Tag pipeline.** Each stage carries `{vld, id, err}`. Stage s1 corresponds to the shifter's first stage and s2 to its result register. On every edge with `dena` high: s1 <= issue tag, s2 <= s1.
- **Response.** `rsp_vld = s2.vld`. `rsp_id` and `rsp_err` come from s2.
- **Stall rule.** `dena = !(rsp_vld && !rsp_rdy)`. While stalled, tags hold, the shifter holds, and no grant is made.
- **Grant.** A grant is made only when `dena` is high, `flush` is low, and at least one `req_vld` bit is set.
  - Round-robin search starts at the requester after `last`. `last` updates only on a grant.
  - The winner gets `req_rdy[w] = 1`. `x_opa`, `x_opb` and `x_imm` are muxed from slice w.
  - The issue tag is `{1, w, knd==3}`.
  - With no grant, the issue tag is a bubble (`vld` = 0) and `x_*` hold the last granted values, so the shifter does not toggle.
- **Reserved kind.** Kind 3 is accepted and shifted; the shifter produces X. The response carries `rsp_err = 1` and `rsp_dat = 0`.
- **Flush.** On the edge where `flush` is high, s1.vld and s2.vld are cleared. No grant is made in a flush cycle. `last` is unchanged.
- **Response and flush together.** A response presented in the same cycle as `flush` is dropped even if `rsp_rdy` is high. The requester must not count it as delivered.
- **Ordering.** Responses return in grant order. There is no per-requester limit.

## Timing
- **Latency.** A request granted in cycle t produces `rsp_vld` in cycle t+2, provided there are no stalls. Each stall cycle adds one cycle.
- **Throughput.** One grant per cycle while `rsp_rdy` is held high.
- **`req_rdy`.** Combinational from `req_vld`, `dena`, `flush` and `last`. There is no combinational path from `m_bsf` to any output other than `rsp_dat`.
- **Reset values.**
  - s1.vld = s2.vld = 0, so `rsp_vld` = 0 and `rsp_err` = 0.
  - `last` = NREQ-1, so requester 0 wins first.
  - `x_opa`, `x_opb` and `x_imm` = 0; `rsp_id` = 0.
  - `req_rdy` = 0 while `grst` is high; `dena` = 1.
- **Reset mid-operation.** In-flight tags are discarded. The shifter's own reset is synchronous, so stale `m_bsf` data may remain after reset; it is never presented because all tag valids are 0.
- **Simultaneous events.**
  - Response and grant in the same cycle is the normal case when `rsp_rdy` is high.
  - If `rsp_rdy` is low while s2 is valid, s1 keeps its tag even if it is a bubble, and the grant is withheld.

## Structure
- **Package `aemb_bsft_pkg`:** kind constants `BSF_SRL` = 2'd0, `BSF_SRA` = 2'd1, `BSF_SLL` = 2'd2, `BSF_RSV` = 2'd3; tag struct `{vld, id, err}`; latency constant `BSF_LAT` = 2.
- **Sub-module `aemb_rr_arb`:** NREQ-wide round-robin arbiter with an enable input and a `last` pointer. It returns a one-hot grant and an encoded id. The arbiter is reused elsewhere.
- **Integration.** The shifter is instantiated outside this block at the parent level, with its `dena` and operand inputs driven from this block.

## Test plan
- **Single request.** Requester 0 sends SLL, opa = 0x0000_0001, opb = 4. Expect `rsp_vld` 2 cycles later with dat = 0x0000_0010 and id = 0.
- **Contention.** Requesters 0 and 1 are both valid every cycle. Expect grants 0,1,0,1. Check SRA with opa = 0x8000_0000, opb = 31 gives 0xFFFF_FFFF, and SRL with the same operands gives 0x0000_0001.
- **Back-pressure.** Hold `rsp_rdy` low for 3 cycles while a response is pending. Expect `dena` = 0, `rsp_dat` stable, no `req_rdy`, and the next response arriving 3 cycles later than unstalled.
- **Reserved kind.** Send kind 3. Expect `rsp_err` = 1, `rsp_dat` = 0 and the correct `rsp_id`. The following SLL by 1 of 0x1 must return 0x2.
- **Flush.** Assert `flush` with two operations in flight. Expect no `rsp_vld` for either, no grant in the flush cycle, and the next grant going to the requester after `last`.
- **Reset.** Assert async `grst` mid-stream. Expect all outputs at their reset values immediately. After release, requester 0 is granted first, and only bits [4:0] of opb = 0xFFFF_FFE3 are honoured (shift by 3).
